// File: rtl/pkt_pkg.sv
// Purpose:      shared types for the per-requestor packet ingress FIFO (beat storage type, read FSM states).
// Latency:      n/a (types and constants only).
// Backpressure: n/a.
package pkt_pkg;

  localparam int DATA_W = 64;

  // One stored beat: payload plus end-of-packet marker.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              tlast;
  } beat_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_t;

endpackage

// File: rtl/pkt_ingress_fifo_if.sv
// Purpose:      bundle of the write stream, arbiter request/grant, read stream and status of one ingress FIFO.
// Latency:      n/a (wires only).
// Backpressure: s_ready_o throttles the writer; m_ready_i throttles the reader.
// Ports:        slave = FIFO side, master = traffic source/sink side.
//               drop_cnt_o exists only when INGRESS_DROP_ON_FULL_EN is defined.
interface pkt_ingress_fifo_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8,
  parameter int LVL_W  = 7
);

  logic              s_valid_i;
  logic [DATA_W-1:0] s_data_i;
  logic              s_tlast_i;
  logic              s_ready_o;
  logic              req_o;
  logic              grant_i;
  logic              m_valid_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_tlast_o;
  logic              m_ready_i;
  logic [CNT_W-1:0]  pkt_cnt_o;
  logic [LVL_W-1:0]  level_o;
`ifdef INGRESS_DROP_ON_FULL_EN
  logic [CNT_W-1:0]  drop_cnt_o;
`endif

  modport slave (
    input  s_valid_i, s_data_i, s_tlast_i, grant_i, m_ready_i,
`ifdef INGRESS_DROP_ON_FULL_EN
    output drop_cnt_o,
`endif
    output s_ready_o, req_o, m_valid_o, m_data_o, m_tlast_o, pkt_cnt_o, level_o
  );

  modport master (
    output s_valid_i, s_data_i, s_tlast_i, grant_i, m_ready_i,
`ifdef INGRESS_DROP_ON_FULL_EN
    input  drop_cnt_o,
`endif
    input  s_ready_o, req_o, m_valid_o, m_data_o, m_tlast_o, pkt_cnt_o, level_o
  );

endinterface

// File: rtl/pkt_ffram.sv
// Purpose:      DEPTH x beat_t flop-array storage for the ingress FIFO.
// Latency:      write lands on the next clk edge; read is combinational from raddr.
// Backpressure: none; the owner guarantees it never overwrites unread entries.
// Ports:        clk, we/waddr/wdata (sync write), raddr/rdata (async read).
module pkt_ffram
  import pkt_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  beat_t         wdata,
  input  logic [AW-1:0] raddr,
  output beat_t         rdata
);

  // Storage is not reset: the pointers alone decide which entries are valid.
  beat_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_ingress_fifo.sv
// Purpose:      store-and-forward packet FIFO ahead of the round-robin arbiter; requests only with whole packets stored.
// Latency:      tlast write in cycle N -> req_o in N+1; grant in N+1 -> m_valid_o in N+2; one idle cycle per packet.
// Backpressure: s_ready_o drops when full (or, with INGRESS_DROP_ON_FULL_EN, stays high and overflowing packets are dropped).
// Ports:        clk, rst_n (async active-low), bus (pkt_ingress_fifo_if.slave): write stream s_*, req_o/grant_i,
//               read stream m_*, pkt_cnt_o (saturating), level_o (entries incl. partial packet), drop_cnt_o (drop build).
module pkt_ingress_fifo #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pkt_ingress_fifo_if.slave bus
);

  import pkt_pkg::*;

  localparam int              AW      = $clog2(DEPTH);
  localparam int              PW      = AW + 1;
  localparam logic [PW-1:0]   DEPTH_P = PW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            ready_q;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   pkt_q;        // exact packet count, drives req_o
  logic [CNT_W-1:0] pkt_cnt_q;   // saturating copy for status
  rd_state_t       state_q, state_d;
  beat_t           wbeat, rbeat;
  logic            full, s_ready, wr_acc, mem_we, wr_rewind, wr_commit;
  logic            rd_fire, rd_last, req;

  assign full   = (wr_ptr - rd_ptr) == DEPTH_P;
  assign wr_acc = bus.s_valid_i && s_ready;

`ifdef INGRESS_DROP_ON_FULL_EN
  logic            dropping_q;
  logic            discard;
  logic [PW-1:0]   commit_ptr;   // end of the last complete packet, rewind target
  logic [CNT_W-1:0] drop_cnt_q;

  // Writer is never stalled; a beat seen while full poisons the rest of its packet.
  assign s_ready   = ready_q;
  assign discard   = wr_acc && (dropping_q || full);
  assign mem_we    = wr_acc && !discard;
  assign wr_rewind = discard && bus.s_tlast_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropping_q <= 1'b0;
      commit_ptr <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (discard) begin
        dropping_q <= !bus.s_tlast_i;
      end
      if (wr_commit) begin
        commit_ptr <= wr_ptr + PW'(1);
      end
      if (wr_rewind && drop_cnt_q != CNT_MAX) begin
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.drop_cnt_o = drop_cnt_q;
`else
  assign s_ready   = ready_q && !full;
  assign mem_we    = wr_acc;
  assign wr_rewind = 1'b0;
`endif

  assign wr_commit   = mem_we && bus.s_tlast_i;
  assign wbeat.data  = bus.s_data_i;
  assign wbeat.tlast = bus.s_tlast_i;

  pkt_ffram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wbeat),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rbeat)
  );

  // ready_q keeps s_ready_o low while reset is held and for the release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      ready_q <= 1'b1;
`ifdef INGRESS_DROP_ON_FULL_EN
      if (wr_rewind) begin
        wr_ptr <= commit_ptr;
      end else if (mem_we) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
`else
      if (mem_we) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
`endif
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Read FSM: only whole packets are ever granted, so SEND never runs dry.
  assign rd_fire = (state_q == RD_SEND) && bus.m_ready_i;
  assign rd_last = rd_fire && rbeat.tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: if (req && bus.grant_i) state_d = RD_SEND;
      RD_SEND: if (rd_last)            state_d = RD_IDLE;
      default:                         state_d = RD_IDLE;
    endcase
  end

  // Packet counters; a commit and a completed read in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      case ({wr_commit, rd_last})
        2'b10: begin
          pkt_q <= pkt_q + PW'(1);
          if (pkt_cnt_q != CNT_MAX) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
        end
        2'b01: begin
          pkt_q <= pkt_q - PW'(1);
          if (pkt_cnt_q != '0) pkt_cnt_q <= pkt_cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign req           = (pkt_q != '0);
  assign bus.req_o     = req;
  assign bus.s_ready_o = s_ready;
  assign bus.m_valid_o = (state_q == RD_SEND);
  assign bus.m_data_o  = (state_q == RD_SEND) ? rbeat.data : '0;
  assign bus.m_tlast_o = (state_q == RD_SEND) && rbeat.tlast;
  assign bus.pkt_cnt_o = pkt_cnt_q;
  assign bus.level_o   = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_pkt_ingress_fifo.sv
// Purpose:      directed self-checking bench for pkt_ingress_fifo (DEPTH=64).
// Latency:      n/a.
// Backpressure: n/a.
module tb_pkt_ingress_fifo;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   bad;

  always #5 clk = ~clk;

  pkt_ingress_fifo_if #(.DATA_W(64), .CNT_W(8), .LVL_W(7)) bus ();

  pkt_ingress_fifo #(.DEPTH(64), .DATA_W(64), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat presented for exactly one edge; caller ensures s_ready_o is high.
  task automatic wr(input logic [63:0] d, input logic last);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = d;
    bus.s_tlast_i = last;
    tick();
    bus.s_valid_i = 1'b0;
    bus.s_tlast_i = 1'b0;
  endtask

  task automatic grant_pulse;
    bus.grant_i = 1'b1;
    tick();
    bus.grant_i = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    bus.s_tlast_i = 1'b0;
    bus.grant_i   = 1'b0;
    bus.m_ready_i = 1'b1;
    #2;
    // Reset state
    check("rst_s_ready", bus.s_ready_o, 0);
    check("rst_req",     bus.req_o,     0);
    check("rst_m_valid", bus.m_valid_o, 0);
    check("rst_pkt_cnt", bus.pkt_cnt_o, 0);
    check("rst_level",   bus.level_o,   0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_release", bus.s_ready_o, 1);

    // Single 3-beat packet
    wr(64'hA0, 1'b0);
    wr(64'hA1, 1'b0);
    check("t1_req_before_tlast", bus.req_o, 0);
    wr(64'hA2, 1'b1);
    check("t1_req_after_tlast", bus.req_o, 1);
    check("t1_pkt_cnt",         bus.pkt_cnt_o, 1);
    check("t1_level",           bus.level_o, 3);
    grant_pulse();
    check("t1_valid",  bus.m_valid_o, 1);
    check("t1_beat0",  bus.m_data_o, 64'hA0);
    check("t1_tlast0", bus.m_tlast_o, 0);
    tick();
    check("t1_beat1",  bus.m_data_o, 64'hA1);
    tick();
    check("t1_beat2",  bus.m_data_o, 64'hA2);
    check("t1_tlast2", bus.m_tlast_o, 1);
    tick();
    check("t1_valid_end", bus.m_valid_o, 0);
    check("t1_req_end",   bus.req_o, 0);
    check("t1_cnt_end",   bus.pkt_cnt_o, 0);
    check("t1_level_end", bus.level_o, 0);
    check("t1_data_idle", bus.m_data_o, 0);

    // Partial packet is withheld from the arbiter
    wr(64'hB0, 1'b0);
    wr(64'hB1, 1'b0);
    grant_pulse();
    check("t2_req",    bus.req_o, 0);
    check("t2_valid",  bus.m_valid_o, 0);
    check("t2_level",  bus.level_o, 2);
    tick();
    check("t2_valid_later", bus.m_valid_o, 0);
    wr(64'hB2, 1'b1);
    check("t2_req_done", bus.req_o, 1);
    grant_pulse();
    check("t2_beat0", bus.m_data_o, 64'hB0);
    tick();
    tick();
    check("t2_beat2", {bus.m_tlast_o, bus.m_data_o}, {1'b1, 64'hB2});
    tick();
    check("t2_level_end", bus.level_o, 0);

    // Backpressure: 64-beat packet fills the FIFO
    for (int i = 0; i < 64; i++) wr(64'(i), (i == 63));
    check("t3_ready_full", bus.s_ready_o, 0);
    check("t3_level_full", bus.level_o, 64);
    check("t3_req",        bus.req_o, 1);
    bus.m_ready_i = 1'b0;
    grant_pulse();
    check("t3_beat0",        bus.m_data_o, 0);
    check("t3_ready_held",   bus.s_ready_o, 0);
    bus.m_ready_i = 1'b1;
    tick();
    check("t3_ready_reopen", bus.s_ready_o, 1);
    check("t3_level_63",     bus.level_o, 63);
    bad = 0;
    for (int i = 1; i < 64; i++) begin
      if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 64'(i) || bus.m_tlast_o !== (i == 63)) bad++;
      tick();
    end
    check("t3_drain_bad", bad, 0);
    check("t3_valid_end", bus.m_valid_o, 0);
    check("t3_level_end", bus.level_o, 0);

    // Simultaneous tlast write and tlast read
    wr(64'hC0, 1'b0);
    wr(64'hC1, 1'b1);
    wr(64'hD0, 1'b1);
    check("t4_cnt2", bus.pkt_cnt_o, 2);
    grant_pulse();
    check("t4_c0", bus.m_data_o, 64'hC0);
    tick();
    check("t4_c1", {bus.m_tlast_o, bus.m_data_o}, {1'b1, 64'hC1});
    wr(64'hE0, 1'b1);
    check("t4_cnt_same", bus.pkt_cnt_o, 2);
    check("t4_req_same", bus.req_o, 1);
    check("t4_idle",     bus.m_valid_o, 0);
    grant_pulse();
    check("t4_d0", bus.m_data_o, 64'hD0);
    tick();
    check("t4_cnt1", bus.pkt_cnt_o, 1);
    grant_pulse();
    check("t4_e0", bus.m_data_o, 64'hE0);
    tick();
    check("t4_cnt0", bus.pkt_cnt_o, 0);
    check("t4_req0", bus.req_o, 0);

    // Stall mid-packet
    wr(64'hF0, 1'b0);
    wr(64'hF1, 1'b0);
    wr(64'hF2, 1'b0);
    wr(64'hF3, 1'b1);
    bus.m_ready_i = 1'b0;
    grant_pulse();
    check("t5_f0", bus.m_data_o, 64'hF0);
    bus.m_ready_i = 1'b1;
    tick();
    check("t5_f1", bus.m_data_o, 64'hF1);
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_stall", {bus.m_valid_o, bus.m_data_o}, {1'b1, 64'hF1});
    end
    bus.m_ready_i = 1'b1;
    tick();
    check("t5_f2", bus.m_data_o, 64'hF2);
    tick();
    check("t5_f3", {bus.m_tlast_o, bus.m_data_o}, {1'b1, 64'hF3});
    tick();
    check("t5_valid_end", bus.m_valid_o, 0);
    check("t5_level_end", bus.level_o, 0);

    // Async reset mid-read and mid-write
    wr(64'h60, 1'b0);
    wr(64'h61, 1'b1);
    bus.m_ready_i = 1'b0;
    grant_pulse();
    check("t6_mid_read", bus.m_valid_o, 1);
    wr(64'h70, 1'b0);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 64'h71;
    rst_n = 1'b0;
    #2;
    check("t6_rst_s_ready", bus.s_ready_o, 0);
    check("t6_rst_req",     bus.req_o, 0);
    check("t6_rst_m_valid", bus.m_valid_o, 0);
    check("t6_rst_m_tlast", bus.m_tlast_o, 0);
    check("t6_rst_m_data",  bus.m_data_o, 0);
    check("t6_rst_pkt_cnt", bus.pkt_cnt_o, 0);
    check("t6_rst_level",   bus.level_o, 0);
    bus.s_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_ready_back", bus.s_ready_o, 1);
    wr(64'h55, 1'b1);
    check("t6_req", bus.req_o, 1);
    bus.m_ready_i = 1'b1;
    grant_pulse();
    check("t6_data55", {bus.m_tlast_o, bus.m_data_o}, {1'b1, 64'h55});
    tick();
    check("t6_level_end", bus.level_o, 0);
    check("t6_req_end",   bus.req_o, 0);

`ifdef INGRESS_DROP_ON_FULL_EN
    // Oversize 70-beat packet is dropped whole
    check("t7_drop0", bus.drop_cnt_o, 0);
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.s_ready_o !== 1'b1) bad++;
      wr(64'(i), (i == 69));
    end
    check("t7_ready_always", bad, 0);
    check("t7_drop1",   bus.drop_cnt_o, 1);
    check("t7_level0",  bus.level_o, 0);
    check("t7_req0",    bus.req_o, 0);
    check("t7_cnt0",    bus.pkt_cnt_o, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
